phase_timer: RTL

- Sequencing controller for the traffic-light phase FSM.
- Watches the FSM's one-hot phase indicators (fsm_g/fsm_y/fsm_r) and times each phase with a per-phase programmable duration in seconds. Durations are set through a small config write port.
- Issues single-cycle g_end/y_end/r_end pulses that advance the FSM.
- Exports the remaining seconds for the countdown display.
- A pedestrian request can shorten an active green phase.

---
 rtl/phase_timer_if.sv | 29 ++
 rtl/phase_timer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/phase_timer_if.sv
// Bundles the phase FSM's indicators, the duration config port, the pedestrian
// request and the timer's outputs. The FSM/controller side takes the master
// modport and phase_timer takes the slave modport.
interface phase_timer_if #(
  parameter int CNT_W = 8
);
  logic             fsm_g;
  logic             fsm_y;
  logic             fsm_r;
  logic             cfg_we;
  logic [1:0]       cfg_sel;
  logic [CNT_W-1:0] cfg_data;
  logic             ped_req;
  logic             g_end;
  logic             y_end;
  logic             r_end;
  logic [CNT_W-1:0] remain;
  logic             sec_tick;

  modport master (
    output fsm_g, fsm_y, fsm_r, cfg_we, cfg_sel, cfg_data, ped_req,
    input  g_end, y_end, r_end, remain, sec_tick
  );

  modport slave (
    input  fsm_g, fsm_y, fsm_r, cfg_we, cfg_sel, cfg_data, ped_req,
    output g_end, y_end, r_end, remain, sec_tick
  );
endinterface

// File: rtl/phase_timer.sv
// Times each traffic-light phase reported by the phase FSM and pulses the
// matching *_end output when its programmed duration (in seconds) runs out.
// The end pulse, sec_tick and the remain decrement all appear in the cycle
// right after the prescaler wraps, so every output comes straight from a flop.
// A pedestrian request raised outside green stays latched until a green phase
// is counting, where it is either applied or dropped.
module phase_timer #(
  parameter int CLK_DIV = 50000000,
  parameter int CNT_W   = 8,
  parameter int G_DEF   = 30,
  parameter int Y_DEF   = 3,
  parameter int R_DEF   = 2,
  parameter int PED_MIN = 5
) (
  input  logic          clk,
  input  logic          rst,
  phase_timer_if.slave  bus
);

  localparam int PW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    WAIT  = 2'd3
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] remain_q;
  logic [PW-1:0]    presc_q;
  logic             ped_q;
  logic [2:0]       prev_phase_q;
  logic [CNT_W-1:0] g_dur_q;
  logic [CNT_W-1:0] y_dur_q;
  logic [CNT_W-1:0] r_dur_q;
  logic             g_end_q;
  logic             y_end_q;
  logic             r_end_q;
  logic             sec_tick_q;

  logic [2:0]       phase;
  logic             phase_valid;
  logic             phase_new;
  logic             in_green;
  logic             ped_eff;
  logic             ped_hit;
  logic             wrap;
  logic [CNT_W-1:0] load_d;

  assign phase       = {bus.fsm_g, bus.fsm_y, bus.fsm_r};
  assign phase_valid = (phase == 3'b100) || (phase == 3'b010) || (phase == 3'b001);
  assign phase_new   = phase_valid && (phase != prev_phase_q);
  assign in_green    = (phase == 3'b100);
  assign ped_eff     = ped_q | bus.ped_req;
  assign ped_hit     = in_green && ped_eff && (remain_q > CNT_W'(PED_MIN));
  assign wrap        = (presc_q == PW'(CLK_DIV - 1));

  // Pick the shadow duration for the phase being loaded; zero means one second.
  always_comb begin
    load_d = r_dur_q;
    case (phase)
      3'b100:  load_d = g_dur_q;
      3'b010:  load_d = y_dur_q;
      default: load_d = r_dur_q;
    endcase
    if (load_d == '0) begin
      load_d = CNT_W'(1);
    end
  end

  // Shadow duration registers; a write only matters at the next LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      g_dur_q <= CNT_W'(G_DEF);
      y_dur_q <= CNT_W'(Y_DEF);
      r_dur_q <= CNT_W'(R_DEF);
    end else if (bus.cfg_we) begin
      case (bus.cfg_sel)
        2'd0:    g_dur_q <= bus.cfg_data;
        2'd1:    y_dur_q <= bus.cfg_data;
        2'd2:    r_dur_q <= bus.cfg_data;
        default: ;
      endcase
    end
  end

  // Phase sequencer: spot a new phase, load its duration, count seconds, pulse its end.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      remain_q     <= '0;
      presc_q      <= '0;
      ped_q        <= 1'b0;
      prev_phase_q <= 3'b000;
      g_end_q      <= 1'b0;
      y_end_q      <= 1'b0;
      r_end_q      <= 1'b0;
      sec_tick_q   <= 1'b0;
    end else begin
      prev_phase_q <= phase;
      g_end_q      <= 1'b0;
      y_end_q      <= 1'b0;
      r_end_q      <= 1'b0;
      sec_tick_q   <= 1'b0;
      if (bus.ped_req) begin
        ped_q <= 1'b1;
      end
      if (!phase_valid) begin
        state_q  <= IDLE;
        remain_q <= '0;
        presc_q  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= LOAD;
          end
          LOAD: begin
            remain_q <= load_d;
            presc_q  <= '0;
            state_q  <= COUNT;
          end
          COUNT: begin
            if (phase_new) begin
              state_q <= LOAD;
            end else begin
              presc_q    <= wrap ? '0 : presc_q + PW'(1);
              sec_tick_q <= wrap;
              if (in_green && ped_eff) begin
                ped_q <= 1'b0;
              end
              if (ped_hit) begin
                remain_q <= CNT_W'(PED_MIN);
              end else if (wrap) begin
                if (remain_q > CNT_W'(1)) begin
                  remain_q <= remain_q - CNT_W'(1);
                end else begin
                  remain_q <= '0;
                  g_end_q  <= bus.fsm_g;
                  y_end_q  <= bus.fsm_y;
                  r_end_q  <= bus.fsm_r;
                  state_q  <= WAIT;
                end
              end
            end
          end
          WAIT: begin
            remain_q <= '0;
            if (phase_new) begin
              state_q <= LOAD;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.g_end    = g_end_q;
  assign bus.y_end    = y_end_q;
  assign bus.r_end    = r_end_q;
  assign bus.remain   = remain_q;
  assign bus.sec_tick = sec_tick_q;

endmodule
